// File: rtl/serv_alu_seq_pkg.sv
// Shared types for the serv_alu sequencer: state encoding and the latched request bundle.
package serv_alu_seq_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic       sub;
    logic [1:0] bool_op;
    logic       cmp_eq;
    logic       cmp_sig;
    logic [2:0] rd_sel;
  } alu_ctrl_t;

  typedef struct packed {
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] buf_w;
    alu_ctrl_t       ctrl;
  } req_t;

endpackage

// File: rtl/serv_sreg.sv
// 32-bit shift register: parallel load, or right shift by W with din entering the top W bits.
module serv_sreg
  import serv_alu_seq_pkg::*;
#(
  parameter int W = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [XLEN-1:0] load_data,
  input  logic            shift,
  input  logic [W-1:0]    din,
  output logic [XLEN-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift) begin
      q <= {din, q[XLEN-1:W]};
    end
  end

endmodule

// File: rtl/serv_alu_seq.sv
// Sequencer around serv_alu: serialises one 32-bit request LSB-first into the ALU and
// reassembles o_rd plus the final compare into a result word.
module serv_alu_seq
  import serv_alu_seq_pkg::*;
#(
  parameter int W = 1
) (
  input  logic            clk,
  input  logic            i_rst_n,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic [XLEN-1:0] i_req_rs1,
  input  logic [XLEN-1:0] i_req_op_b,
  input  logic [XLEN-1:0] i_req_buf,
  input  logic            i_req_sub,
  input  logic [1:0]      i_req_bool_op,
  input  logic            i_req_cmp_eq,
  input  logic            i_req_cmp_sig,
  input  logic [2:0]      i_req_rd_sel,
  output logic            o_alu_en,
  output logic            o_alu_cnt0,
  output logic            o_alu_sub,
  output logic [1:0]      o_alu_bool_op,
  output logic            o_alu_cmp_eq,
  output logic            o_alu_cmp_sig,
  output logic [2:0]      o_alu_rd_sel,
  output logic [W-1:0]    o_alu_rs1,
  output logic [W-1:0]    o_alu_op_b,
  output logic [W-1:0]    o_alu_buf,
  input  logic [W-1:0]    i_alu_rd,
  input  logic            i_alu_cmp,
  output logic            o_res_valid,
  input  logic            i_res_ready,
  output logic [XLEN-1:0] o_res_data,
  output logic            o_res_cmp,
  output state_t          dbg_state
);

  localparam int N  = XLEN / W;
  localparam int CW = $clog2(N);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // Request side is ready only in IDLE; result side is valid only in DONE.
  state_t          state;
  logic [CW-1:0]   cnt;
  alu_ctrl_t       ctrl;
  logic            res_cmp;
  req_t            req;
  logic            accept;
  logic            run;
  logic [XLEN-1:0] rs1_q;
  logic [XLEN-1:0] op_b_q;
  logic [XLEN-1:0] buf_q;
  logic [XLEN-1:0] rd_q;

  assign req = {i_req_rs1, i_req_op_b, i_req_buf,
                i_req_sub, i_req_bool_op, i_req_cmp_eq, i_req_cmp_sig, i_req_rd_sel};

  assign accept = (state == ST_IDLE) && i_req_valid;
  assign run    = (state == ST_RUN);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      ctrl    <= '0;
      res_cmp <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_req_valid) begin
            ctrl  <= req.ctrl;
            state <= ST_PREP;
          end
        end
        ST_PREP: begin
          cnt   <= '0;
          state <= ST_RUN;
        end
        ST_RUN: begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            res_cmp <= i_alu_cmp;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (i_res_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Operands shift out with zero fill; rd starts cleared and fills from the top.
  serv_sreg #(.W(W)) u_rs1 (
    .clk(clk), .rst_n(i_rst_n), .load(accept), .load_data(req.rs1),
    .shift(run), .din({W{1'b0}}), .q(rs1_q)
  );
  serv_sreg #(.W(W)) u_op_b (
    .clk(clk), .rst_n(i_rst_n), .load(accept), .load_data(req.op_b),
    .shift(run), .din({W{1'b0}}), .q(op_b_q)
  );
  serv_sreg #(.W(W)) u_buf (
    .clk(clk), .rst_n(i_rst_n), .load(accept), .load_data(req.buf_w),
    .shift(run), .din({W{1'b0}}), .q(buf_q)
  );
  serv_sreg #(.W(W)) u_rd (
    .clk(clk), .rst_n(i_rst_n), .load(accept), .load_data({XLEN{1'b0}}),
    .shift(run), .din(i_alu_rd), .q(rd_q)
  );

  assign o_req_ready   = (state == ST_IDLE);
  assign o_alu_en      = run;
  assign o_alu_cnt0    = run && (cnt == '0);
  assign o_alu_sub     = ctrl.sub;
  assign o_alu_bool_op = ctrl.bool_op;
  assign o_alu_cmp_eq  = ctrl.cmp_eq;
  assign o_alu_cmp_sig = ctrl.cmp_sig;
  assign o_alu_rd_sel  = ctrl.rd_sel;
  assign o_alu_rs1     = rs1_q[W-1:0];
  assign o_alu_op_b    = op_b_q[W-1:0];
  assign o_alu_buf     = buf_q[W-1:0];
  assign o_res_valid   = (state == ST_DONE);
  assign o_res_data    = rd_q;
  assign o_res_cmp     = res_cmp;
  assign dbg_state     = state;

endmodule

// File: tb/tb_serv_alu_seq.sv
// Bench for serv_alu_seq with a behavioural serial ALU attached and a word-level reference.
module tb_serv_alu_seq;
  import serv_alu_seq_pkg::*;

  localparam int W = 1;
  localparam int N = 32 / W;

  logic        clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic [31:0] i_req_rs1 = '0, i_req_op_b = '0, i_req_buf = '0;
  logic        i_req_sub = 1'b0;
  logic [1:0]  i_req_bool_op = '0;
  logic        i_req_cmp_eq = 1'b0, i_req_cmp_sig = 1'b0;
  logic [2:0]  i_req_rd_sel = '0;
  logic        o_alu_en, o_alu_cnt0, o_alu_sub, o_alu_cmp_eq, o_alu_cmp_sig;
  logic [1:0]  o_alu_bool_op;
  logic [2:0]  o_alu_rd_sel;
  logic [W-1:0] o_alu_rs1, o_alu_op_b, o_alu_buf, i_alu_rd;
  logic        i_alu_cmp;
  logic        o_res_valid;
  logic        i_res_ready = 1'b0;
  logic [31:0] o_res_data;
  logic        o_res_cmp;
  state_t      dbg_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic exp_sub = 1'b0;
  // {check_cmp, cmp, data}
  logic [33:0] exp_q[$];

  serv_alu_seq #(.W(W)) dut (
    .clk(clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_rs1(i_req_rs1), .i_req_op_b(i_req_op_b), .i_req_buf(i_req_buf),
    .i_req_sub(i_req_sub), .i_req_bool_op(i_req_bool_op), .i_req_cmp_eq(i_req_cmp_eq),
    .i_req_cmp_sig(i_req_cmp_sig), .i_req_rd_sel(i_req_rd_sel),
    .o_alu_en(o_alu_en), .o_alu_cnt0(o_alu_cnt0), .o_alu_sub(o_alu_sub),
    .o_alu_bool_op(o_alu_bool_op), .o_alu_cmp_eq(o_alu_cmp_eq), .o_alu_cmp_sig(o_alu_cmp_sig),
    .o_alu_rd_sel(o_alu_rd_sel), .o_alu_rs1(o_alu_rs1), .o_alu_op_b(o_alu_op_b),
    .o_alu_buf(o_alu_buf), .i_alu_rd(i_alu_rd), .i_alu_cmp(i_alu_cmp),
    .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
    .o_res_data(o_res_data), .o_res_cmp(o_res_cmp), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural serial ALU ----------------
  logic         alu_cy = 1'b0;
  logic         alu_eq_r = 1'b0;
  logic [W-1:0] opb_x, bool_r;
  logic [W:0]   add_sum;
  logic         eq_now, lt_now;

  always_comb begin
    opb_x   = o_alu_op_b ^ {W{o_alu_sub}};
    add_sum = {1'b0, o_alu_rs1} + {1'b0, opb_x} + {{W{1'b0}}, alu_cy};
    bool_r  = ((o_alu_rs1 ^ o_alu_op_b) & ~{W{o_alu_bool_op[0]}}) |
              ({W{o_alu_bool_op[1]}} & o_alu_rs1 & o_alu_op_b);
    eq_now  = (add_sum[W-1:0] == '0) & (o_alu_cnt0 | alu_eq_r);
    if (o_alu_rs1[W-1] ^ o_alu_op_b[W-1])
      lt_now = o_alu_cmp_sig ? o_alu_rs1[W-1] : o_alu_op_b[W-1];
    else
      lt_now = add_sum[W-1];
    i_alu_cmp = o_alu_cmp_eq ? eq_now : lt_now;
    i_alu_rd  = o_alu_buf | ({W{o_alu_rd_sel[0]}} & add_sum[W-1:0]) |
                ({W{o_alu_rd_sel[2]}} & bool_r);
  end

  always @(posedge clk) begin
    alu_cy   <= o_alu_en ? add_sum[W] : o_alu_sub;
    alu_eq_r <= eq_now;
  end

  // ---------------- reference model ----------------
  function automatic logic [33:0] ref_res(input logic [31:0] a, b, bw, input logic sub,
                                          input logic [1:0] bop, input logic eq, sig,
                                          input logic [2:0] sel, input logic chk);
    logic [31:0] sum, bl, rd;
    logic c;
    sum = sub ? (a - b) : (a + b);
    case (bop)
      2'b00:   bl = a ^ b;
      2'b10:   bl = a | b;
      2'b11:   bl = a & b;
      default: bl = 32'h0;
    endcase
    rd = bw | (sel[0] ? sum : 32'h0) | (sel[2] ? bl : 32'h0);
    if (eq) c = (sum == 32'h0);
    else if (sig) c = ($signed(a) < $signed(b));
    else c = (a < b);
    return {chk, c, rd};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] a, b, bw, input logic sub, input logic [1:0] bop,
                      input logic eq, sig, input logic [2:0] sel, input logic chk);
    int budget;
    i_req_rs1 = a; i_req_op_b = b; i_req_buf = bw; i_req_sub = sub;
    i_req_bool_op = bop; i_req_cmp_eq = eq; i_req_cmp_sig = sig; i_req_rd_sel = sel;
    i_req_valid = 1'b1;
    budget = 0;
    while (!o_req_ready && budget < 200) begin
      step();
      budget++;
    end
    check("req_ready_wait", {31'b0, o_req_ready}, 32'd1);
    exp_q.push_back(ref_res(a, b, bw, sub, bop, eq, sig, sel, chk));
    exp_sub = sub;
    step();
    acc_cyc = cyc;
    i_req_valid = 1'b0;
  endtask

  task automatic get_result(input string tag, input int hold);
    int budget, en_n, c0_n;
    logic [33:0] e;
    budget = 0; en_n = 0; c0_n = 0;
    check({tag, "_prep_sub"}, {31'b0, o_alu_sub}, {31'b0, exp_sub});
    while (!o_res_valid && budget < 4 * N + 20) begin
      if (o_alu_en) en_n++;
      if (o_alu_cnt0) c0_n++;
      step();
      budget++;
    end
    check({tag, "_valid"}, {31'b0, o_res_valid}, 32'd1);
    // The cycle following edge e is numbered e+1.
    check({tag, "_latency"}, 32'(cyc + 1 - acc_cyc), 32'(N + 2));
    check({tag, "_en_cycles"}, 32'(en_n), 32'(N));
    check({tag, "_cnt0_cycles"}, 32'(c0_n), 32'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      for (int i = 0; i < hold; i++) begin
        check({tag, "_hold_data"}, o_res_data, exp_q[0][31:0]);
        check({tag, "_hold_ready"}, {31'b0, o_req_ready}, 32'd0);
        check({tag, "_hold_en"}, {31'b0, o_alu_en}, 32'd0);
        step();
      end
      i_res_ready = 1'b1;
      e = exp_q.pop_front();
      check({tag, "_data"}, o_res_data, e[31:0]);
      if (e[33]) check({tag, "_cmp"}, {31'b0, o_res_cmp}, {31'b0, e[32]});
      step();
      i_res_ready = 1'b0;
      check({tag, "_idle_after"}, {31'b0, o_req_ready}, 32'd1);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int en_seen, budget;
    logic [31:0] ra, rb;
    logic rs;

    step();
    step();
    check("rst_ready", {31'b0, o_req_ready}, 32'd1);
    check("rst_valid", {31'b0, o_res_valid}, 32'd0);
    check("rst_en", {31'b0, o_alu_en}, 32'd0);
    check("rst_data", o_res_data, 32'd0);
    i_rst_n = 1'b1;
    step();
    check("post_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("post_rst_cmp", {31'b0, o_res_cmp}, 32'd0);
    check("post_rst_cnt0", {31'b0, o_alu_cnt0}, 32'd0);

    send(32'd5, 32'd7, 32'd0, 1'b0, 2'b00, 1'b0, 1'b0, 3'b001, 1'b0);
    get_result("add", 0);

    send(32'h12345678, 32'h12345678, 32'd0, 1'b1, 2'b00, 1'b1, 1'b0, 3'b001, 1'b1);
    get_result("sub_eq", 0);
    send(32'h12345678, 32'h12345679, 32'd0, 1'b1, 2'b00, 1'b1, 1'b0, 3'b001, 1'b1);
    get_result("sub_ne", 0);

    send(32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 2'b00, 1'b0, 1'b1, 3'b001, 1'b1);
    get_result("slt_signed", 0);
    send(32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 2'b00, 1'b0, 1'b0, 3'b001, 1'b1);
    get_result("slt_unsigned", 0);

    send(32'hF0F0F0F0, 32'hFF00FF00, 32'h0000000F, 1'b0, 2'b11, 1'b0, 1'b0, 3'b100, 1'b0);
    get_result("and_buf", 0);

    // Backpressure with a competing request held valid throughout.
    send(32'hA5A5A5A5, 32'h0F0F0F0F, 32'd0, 1'b0, 2'b10, 1'b0, 1'b0, 3'b100, 1'b0);
    i_req_rs1 = 32'd3; i_req_op_b = 32'd4; i_req_sub = 1'b0; i_req_rd_sel = 3'b001;
    i_req_valid = 1'b1;
    get_result("bp", 10);
    exp_q.push_back(ref_res(32'd3, 32'd4, 32'd0, 1'b0, 2'b11, 1'b0, 1'b0, 3'b001, 1'b0));
    exp_sub = 1'b0;
    step();
    acc_cyc = cyc;
    i_req_valid = 1'b0;
    check("bp_next_prep", 32'(dbg_state), 32'(ST_PREP));
    get_result("bp_next", 0);

    for (int k = 0; k < 4; k++) begin
      ra = $urandom; rb = (k == 1) ? ra : $urandom;
      rs = 1'($urandom_range(0, 1));
      send(ra, rb, 32'd0, rs, 2'b00, 1'b1, 1'b0, 3'b001, 1'b1);
      get_result("rand", 0);
    end

    // Reset in the middle of RUN, at count 12.
    send(32'h11111111, 32'h22222222, 32'd0, 1'b0, 2'b00, 1'b0, 1'b0, 3'b001, 1'b0);
    en_seen = 0; budget = 0;
    while (budget < 100) begin
      if (o_alu_en) en_seen++;
      if (en_seen == 13) break;
      step();
      budget++;
    end
    check("mid_run_reached", 32'(en_seen), 32'd13);
    i_rst_n = 1'b0;
    #1;
    check("mid_rst_en", {31'b0, o_alu_en}, 32'd0);
    check("mid_rst_valid", {31'b0, o_res_valid}, 32'd0);
    check("mid_rst_ready", {31'b0, o_req_ready}, 32'd1);
    exp_q.delete();
    step();
    i_rst_n = 1'b1;
    step();
    send(32'd1, 32'd1, 32'd0, 1'b0, 2'b00, 1'b0, 1'b0, 3'b001, 1'b0);
    get_result("after_rst_add", 0);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serv_alu_seq.md
Name: serv_alu_seq

Overview:
Sequencer that sits directly around serv_alu as its upstream and downstream stage. Accepts one parallel 32-bit operation (rs1, op_b, buf word, ALU controls) over a valid/ready handshake. Serialises the operands LSB-first, W bits per cycle, into the ALU and drives i_en/i_cnt0. Deserialises o_rd back into a 32-bit word, captures the final o_cmp, and presents both over a second valid/ready handshake.

Parameters:
W, 1, serial datapath width per cycle; legal values 1, 2, 4, 8; must match the ALU's W
N, 32/W, derived (localparam): serial cycles per operation

Ports:
clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_req_valid  in  1  request valid
o_req_ready  out  1  request accepted when high with i_req_valid
i_req_rs1  in  32  operand rs1
i_req_op_b  in  32  operand b
i_req_buf  in  32  buffer word, ORed into rd by ALU
i_req_sub  in  1  subtract
i_req_bool_op  in  2  bool op
i_req_cmp_eq  in  1  equality compare
i_req_cmp_sig  in  1  signed compare
i_req_rd_sel  in  3  rd select
o_alu_en  out  1  to ALU i_en
o_alu_cnt0  out  1  to ALU i_cnt0
o_alu_sub, o_alu_bool_op, o_alu_cmp_eq, o_alu_cmp_sig, o_alu_rd_sel  out  1/2/1/1/3  latched controls to ALU
o_alu_rs1, o_alu_op_b, o_alu_buf  out  W each  serial operands to ALU
i_alu_rd  in  W  ALU o_rd
i_alu_cmp  in  1  ALU o_cmp
o_res_valid  out  1  result valid
i_res_ready  in  1  result consumed when high with o_res_valid
o_res_data  out  32  deserialised rd word
o_res_cmp  out  1  final compare result

Behaviour:
- Reset (async, i_rst_n low): state IDLE. All outputs 0 except o_req_ready=1. All shift registers, counter, and latched controls cleared. Reset mid-operation aborts the operation and discards it.
- States: IDLE, PREP, RUN, DONE.
- IDLE: o_req_ready=1. On i_req_valid, latch all request fields and go to PREP.
- PREP: exactly one cycle. o_alu_en=0 with o_alu_sub already driving the latched sub, so the ALU carry register preloads i_sub. Go to RUN.
- RUN: o_alu_en=1 for exactly N cycles. A cycle counter counts 0..N-1.
  - o_alu_cnt0=1 only when the count is 0.
  - o_alu_rs1, o_alu_op_b and o_alu_buf are the low W bits of their shift registers. Each register shifts right by W every RUN cycle.
  - i_alu_rd is shifted into the top W bits of the result register.
  - On the last cycle (count N-1), capture i_alu_cmp into o_res_cmp and go to DONE.
- DONE: o_res_valid=1, with o_res_data/o_res_cmp stable. On i_res_ready, go to IDLE.
- o_req_ready is 0 in PREP/RUN/DONE. A request is never accepted in the same cycle as a result hand-off; acceptance happens earliest the next cycle.
- Latency: accept at edge t, PREP in cycle t+1, RUN in cycles t+2..t+N+1, o_res_valid from cycle t+N+2. For W=1 this is t+34.
- Throughput: one operation per N+3 cycles when i_res_ready is held high.
- Controls to the ALU hold their latched values from PREP through DONE and change only on a new accept.
- Backpressure: while in DONE with i_res_ready=0, all outputs are held and o_alu_en stays 0.
- No X propagation: operand shift registers fill with 0 as they shift.

Decomposition:
- Shared package: XLEN=32; state encoding (IDLE=2'd0, PREP=2'd1, RUN=2'd2, DONE=2'd3); a request struct bundling rs1, op_b, buf and controls.
- One natural sub-module, serv_sreg: a 32-bit shift register with parallel load and right-shift by W.
  - Instantiated three times for rs1, op_b and buf, in load/shift-out mode.
  - Instantiated once for rd, in shift-in-at-MSB mode.
- serv_alu is instantiated by the parent, not inside this block.

Test Plan:
- ADD: rs1=5, op_b=7, sub=0, rd_sel=001, W=1 (with serv_alu attached) -> o_res_data=0x0000000C, o_res_valid at accept+34.
- SUB/EQ: rs1=op_b=0x12345678, sub=1, cmp_eq=1, rd_sel=001 -> o_res_data=0, o_res_cmp=1; repeat with op_b=0x12345679 -> o_res_cmp=0.
- Signed vs unsigned LT: rs1=0xFFFFFFFF, op_b=1, sub=1, cmp_eq=0. With cmp_sig=1 -> o_res_cmp=1; with cmp_sig=0 -> o_res_cmp=0.
- AND plus buf: rs1=0xF0F0F0F0, op_b=0xFF00FF00, bool_op=11, rd_sel=100, buf=0x0000000F -> o_res_data=0xF000F00F. Repeat with W=4 -> same data, valid at accept+10.
- Backpressure: hold i_res_ready=0 for 10 cycles with i_req_valid=1 -> o_res_data stable, o_req_ready=0, no second accept. Release -> IDLE, new request accepted the following cycle.
- Reset mid-RUN: assert i_rst_n=0 at RUN count 12 -> immediately o_alu_en=0, o_res_valid=0, o_req_ready=1. The next ADD 1+1 -> o_res_data=2.
